// File: rtl/axis_pad_pkg.sv
// Shared widths, beat layout and skid-buffer state encoding for the axis_pad block.
package axis_pad_pkg;

  localparam int IN_W  = 24;
  localparam int OUT_W = 32;
  localparam int PAD_W = 8;

  localparam logic [PAD_W-1:0] PAD_VALUE_DEFAULT = 8'h00;

  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            last;
    logic            sof;
  } beat_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_t;

  function automatic logic [OUT_W-1:0] pad_beat(input logic [PAD_W-1:0] pad,
                                                input logic [IN_W-1:0]  data);
    return {pad, data};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry skid buffer: main register M drives the output, skid register S
// catches the one beat accepted while the output stalls. Ready is registered.
module axis_skid_buf
  import axis_pad_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [1:0]   o_state
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // valid never waits on ready and payload holds while valid is high and ready is low.
  skid_state_t r_state;
  skid_state_t w_state_next;
  logic [W-1:0] r_m_data;
  logic [W-1:0] r_s_data;
  logic         r_ready;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_load_m_in;
  logic         w_load_m_s;
  logic         w_load_s;

  assign w_in_fire  = i_valid & r_ready;
  assign w_out_fire = (r_state != SKID_EMPTY) & i_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= SKID_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SKID_EMPTY: if (w_in_fire) w_state_next = SKID_ONE;
      SKID_ONE: begin
        if (w_in_fire && !w_out_fire)      w_state_next = SKID_FULL;
        else if (!w_in_fire && w_out_fire) w_state_next = SKID_EMPTY;
      end
      SKID_FULL:  if (w_out_fire) w_state_next = SKID_ONE;
      default:    w_state_next = SKID_EMPTY;
    endcase
  end

  always_comb begin
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    case (r_state)
      SKID_EMPTY: w_load_m_in = w_in_fire;
      SKID_ONE: begin
        w_load_m_in = w_in_fire & w_out_fire;
        w_load_s    = w_in_fire & ~w_out_fire;
      end
      SKID_FULL:  w_load_m_s = w_out_fire;
      default: ;
    endcase
  end

  // Ready for the next cycle is simply "skid slot will be free".
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_data <= '0;
      r_s_data <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= (w_state_next != SKID_FULL);
      if (w_load_m_in)     r_m_data <= i_data;
      else if (w_load_m_s) r_m_data <= r_s_data;
      if (w_load_s)        r_s_data <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != SKID_EMPTY);
  assign o_data  = r_m_data;
  assign o_state = r_state;

endmodule

// File: rtl/axis_pad.sv
// 24->32 bit AXI4-Stream widener with pad byte, registered skid buffer and debug counters.
// Define AXIS_PAD_SOF_EN to add out_AXIS_tuser marking the first beat of each packet.
module axis_pad
  import axis_pad_pkg::*;
#(
  parameter logic [PAD_W-1:0] PAD_VALUE = PAD_VALUE_DEFAULT,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_AXIS_tdata,
  input  logic             in_AXIS_tvalid,
  input  logic             in_AXIS_tlast,
  output logic             in_AXIS_tready,
  output logic [OUT_W-1:0] out_AXIS_tdata,
  output logic             out_AXIS_tvalid,
  output logic             out_AXIS_tlast,
  input  logic             out_AXIS_tready,
  output logic [CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] pkt_count,
  output logic [1:0]       dbg_state
`ifdef AXIS_PAD_SOF_EN
  ,
  output logic             out_AXIS_tuser
`endif
);

  logic            w_in_ready;
  logic            w_out_valid;
  logic [IN_W-1:0] w_out_data;
  logic            w_out_last;
  logic            w_in_fire;
  logic            w_out_fire;

`ifdef AXIS_PAD_SOF_EN
  localparam int PL_W = $bits(beat_t);
  beat_t w_in_beat;
  beat_t w_out_beat;
  logic  r_sof_pending;

  // The beat after reset or after any tlast opens a new packet.
  always_ff @(posedge clk) begin
    if (reset)          r_sof_pending <= 1'b1;
    else if (w_in_fire) r_sof_pending <= in_AXIS_tlast;
  end

  logic [PL_W-1:0] w_in_pl;
  logic [PL_W-1:0] w_out_pl;
  assign w_in_beat      = '{data: in_AXIS_tdata, last: in_AXIS_tlast, sof: r_sof_pending};
  assign w_in_pl        = w_in_beat;
  assign w_out_beat     = beat_t'(w_out_pl);
  assign w_out_data     = w_out_beat.data;
  assign w_out_last     = w_out_beat.last;
  assign out_AXIS_tuser = w_out_valid & w_out_beat.sof;
`else
  localparam int PL_W = IN_W + 1;
  logic [PL_W-1:0] w_in_pl;
  logic [PL_W-1:0] w_out_pl;
  assign w_in_pl    = {in_AXIS_tdata, in_AXIS_tlast};
  assign w_out_data = w_out_pl[PL_W-1:1];
  assign w_out_last = w_out_pl[0];
`endif

  axis_skid_buf #(.W(PL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_data  (w_in_pl),
    .i_valid (in_AXIS_tvalid),
    .o_ready (w_in_ready),
    .o_data  (w_out_pl),
    .o_valid (w_out_valid),
    .i_ready (out_AXIS_tready),
    .o_state (dbg_state)
  );

  assign w_in_fire  = in_AXIS_tvalid & w_in_ready;
  assign w_out_fire = w_out_valid & out_AXIS_tready;

  assign in_AXIS_tready  = w_in_ready;
  assign out_AXIS_tvalid = w_out_valid;
  assign out_AXIS_tdata  = w_out_valid ? pad_beat(PAD_VALUE, w_out_data) : '0;
  assign out_AXIS_tlast  = w_out_valid & w_out_last;

  logic [CNT_W-1:0] r_beat_count;
  logic [CNT_W-1:0] r_pkt_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_count <= '0;
      r_pkt_count  <= '0;
    end else begin
      if (w_in_fire) r_beat_count <= in_AXIS_tlast ? '0 : r_beat_count + 1'b1;
      if (w_out_fire && w_out_last) r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

  assign beat_count = r_beat_count;
  assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_axis_pad.sv
// Testbench for axis_pad: reset, streaming vector table, backpressure, random scoreboard,
// single-beat packets, reset with a full buffer, counter wrap and ready toggling.
module tb_axis_pad;

  localparam logic [7:0] PAD   = 8'hFF;
  localparam int         CNT_W = 4;
  localparam int         CMOD  = 1 << CNT_W;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic [23:0]      in_tdata   = '0;
  logic             in_tvalid  = 1'b0;
  logic             in_tlast   = 1'b0;
  logic             in_tready;
  logic [31:0]      out_tdata;
  logic             out_tvalid;
  logic             out_tlast;
  logic             out_tready = 1'b0;
  logic [CNT_W-1:0] beat_count;
  logic [CNT_W-1:0] pkt_count;
  logic [1:0]       dbg_state;
`ifdef AXIS_PAD_SOF_EN
  logic             out_tuser;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axis_pad #(.PAD_VALUE(PAD), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_AXIS_tdata   (in_tdata),
    .in_AXIS_tvalid  (in_tvalid),
    .in_AXIS_tlast   (in_tlast),
    .in_AXIS_tready  (in_tready),
    .out_AXIS_tdata  (out_tdata),
    .out_AXIS_tvalid (out_tvalid),
    .out_AXIS_tlast  (out_tlast),
    .out_AXIS_tready (out_tready),
    .beat_count      (beat_count),
    .pkt_count       (pkt_count),
    .dbg_state       (dbg_state)
`ifdef AXIS_PAD_SOF_EN
    ,
    .out_AXIS_tuser  (out_tuser)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
  endtask

  // Reference model: a FIFO of accepted beats (occupancy 0..2), packet/beat counters
  // derived from the stream rules, sampled on the falling edge.
  logic [33:0] exp_q[$];
  int          m_beat;
  int          m_pkt;
  logic        m_sof;
  logic        m_ready;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        mon_in_fire;
  logic        mon_out_fire;
  int          out_fires = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_beat     = 0;
      m_pkt      = 0;
      m_sof      = 1'b1;
      m_ready    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("out_valid", out_tvalid, exp_q.size() > 0);
      check("in_ready", in_tready, m_ready);
      check("beat_count", beat_count, m_beat);
      check("pkt_count", pkt_count, m_pkt);
      if (out_tvalid && exp_q.size() > 0) begin
        check("out_data", out_tdata, exp_q[0][31:0]);
        check("out_last", out_tlast, exp_q[0][32]);
`ifdef AXIS_PAD_SOF_EN
        check("out_tuser", out_tuser, exp_q[0][33]);
`endif
      end
      if (prev_stall) begin
        check("hold_data", out_tdata, prev_data);
        check("hold_last", out_tlast, prev_last);
      end
      mon_in_fire  = in_tvalid & in_tready;
      mon_out_fire = out_tvalid & out_tready;
      prev_stall   = out_tvalid & ~out_tready;
      prev_data    = out_tdata;
      prev_last    = out_tlast;
      if (mon_out_fire) begin
        out_fires++;
        if (exp_q.size() > 0) begin
          if (exp_q[0][32]) m_pkt = (m_pkt + 1) % CMOD;
          void'(exp_q.pop_front());
        end
      end
      if (mon_in_fire) begin
        exp_q.push_back({m_sof, in_tlast, PAD, in_tdata});
        m_beat = in_tlast ? 0 : (m_beat + 1) % CMOD;
        m_sof  = in_tlast;
      end
      m_ready = (exp_q.size() < 2);
    end
  end

  typedef struct {
    logic [23:0] din;
    logic        lst;
    logic [31:0] dout;
    logic        olst;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   acc;
    int   budget;
    int   fires0;
    logic f;
    logic took;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{din: 24'(i + 1), lst: (i == 7), dout: {PAD, 24'(i + 1)}, olst: (i == 7)};

    // Reset values
    repeat (2) cycle();
    check("rst_valid", out_tvalid, 1'b0);
    check("rst_tdata", out_tdata, 32'h0);
    check("rst_tlast", out_tlast, 1'b0);
    check("rst_ready", in_tready, 1'b0);
    check("rst_beat", beat_count, 0);
    check("rst_pkt", pkt_count, 0);
    reset = 1'b0;
    cycle();
    check("post_rst_ready", in_tready, 1'b1);

    // Streaming table, one beat per cycle, one cycle latency
    out_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_tdata  = vecs[i].din;
      in_tlast  = vecs[i].lst;
      in_tvalid = 1'b1;
      check("stream_ready", in_tready, 1'b1);
      cycle();
      check("stream_valid", out_tvalid, 1'b1);
      check("stream_data", out_tdata, vecs[i].dout);
      check("stream_last", out_tlast, vecs[i].olst);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    check("stream_beat0", beat_count, 0);
    cycle();
    check("stream_pkt1", pkt_count, 1);
    check("stream_drained", out_tvalid, 1'b0);

    // Backpressure: fill M and S, hold, then release
    do_reset();
    in_tdata = 24'hA0A0A0; in_tlast = 1'b0; in_tvalid = 1'b1;
    cycle();
    check("bp_out_a", out_tdata, {PAD, 24'hA0A0A0});
    check("bp_ready_one", in_tready, 1'b1);
    in_tdata = 24'hB1B1B1;
    cycle();
    check("bp_ready_full", in_tready, 1'b0);
    check("bp_hold_a", out_tdata, {PAD, 24'hA0A0A0});
    in_tdata = 24'hC2C2C2; in_tlast = 1'b1;
    cycle();
    check("bp_hold_a2", out_tdata, {PAD, 24'hA0A0A0});
    check("bp_ready_full2", in_tready, 1'b0);
    out_tready = 1'b1;
    cycle();
    check("bp_out_b", out_tdata, {PAD, 24'hB1B1B1});
    check("bp_ready_back", in_tready, 1'b1);
    cycle();
    check("bp_out_c", out_tdata, {PAD, 24'hC2C2C2});
    check("bp_out_c_last", out_tlast, 1'b1);
    in_tvalid = 1'b0; in_tlast = 1'b0;
    cycle();
    check("bp_pkt", pkt_count, 1);

    // Randomised 100-beat scoreboard run
    acc = 0; budget = 0; took = 1'b1;
    while (acc < 100 && budget < 5000) begin
      if (!in_tvalid || took) begin
        in_tvalid = ($urandom_range(0, 3) != 0);
        in_tdata  = 24'($urandom);
        in_tlast  = ($urandom_range(0, 7) == 0);
      end
      out_tready = ($urandom_range(0, 2) != 0);
      f = in_tvalid & in_tready;
      cycle();
      took = f;
      if (f) acc++;
      budget++;
    end
    check("rand_accepted", acc, 100);
    in_tvalid = 1'b0; out_tready = 1'b1;
    repeat (3) cycle();
    check("rand_drained", out_tvalid, 1'b0);

    // Five single-beat packets
    do_reset();
    out_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_tdata = 24'(16 + i); in_tlast = 1'b1; in_tvalid = 1'b1;
      cycle();
      check("single_beat0", beat_count, 0);
`ifdef AXIS_PAD_SOF_EN
      check("single_tuser", out_tuser, 1'b1);
`endif
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
    cycle();
    check("single_pkt5", pkt_count, 5);

    // Reset while the buffer is full and mid-packet
    do_reset();
    in_tdata = 24'h111111; in_tvalid = 1'b1;
    cycle();
    in_tdata = 24'h222222;
    cycle();
    check("full_ready", in_tready, 1'b0);
    check("full_beat2", beat_count, 2);
    reset = 1'b1; in_tvalid = 1'b0;
    cycle();
    check("rstfull_valid", out_tvalid, 1'b0);
    check("rstfull_tdata", out_tdata, 32'h0);
    check("rstfull_beat", beat_count, 0);
    check("rstfull_pkt", pkt_count, 0);
    reset = 1'b0;
    cycle();
    check("rstfull_ready", in_tready, 1'b1);
    in_tdata = 24'h123456; in_tlast = 1'b1; in_tvalid = 1'b1; out_tready = 1'b1;
    cycle();
    check("rstfull_first", out_tdata, {PAD, 24'h123456});
`ifdef AXIS_PAD_SOF_EN
    check("rstfull_tuser", out_tuser, 1'b1);
`endif
    in_tvalid = 1'b0; in_tlast = 1'b0;
    cycle();

    // Counter wrap with 4-bit counters
    do_reset();
    out_tready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_tdata = 24'(i); in_tlast = 1'b1; in_tvalid = 1'b1;
      cycle();
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
    cycle();
    check("wrap_pkt", pkt_count, 1);
    for (int i = 0; i < 20; i++) begin
      in_tdata = 24'(100 + i); in_tvalid = 1'b1;
      cycle();
    end
    in_tvalid = 1'b0;
    check("wrap_beat", beat_count, 4);
    cycle();

    // Output ready toggling every cycle with input always valid
    do_reset();
    in_tdata = 24'h000100; in_tlast = 1'b0; in_tvalid = 1'b1;
    fires0 = out_fires;
    for (int i = 0; i < 40; i++) begin
      out_tready = ~out_tready;
      f = in_tvalid & in_tready;
      cycle();
      if (f) in_tdata = in_tdata + 24'd1;
    end
    check("toggle_rate", ((out_fires - fires0) >= 19) && ((out_fires - fires0) <= 20), 1'b1);
    in_tvalid = 1'b0; out_tready = 1'b1;
    repeat (3) cycle();
    check("toggle_drained", out_tvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_pad.md
Name: axis_pad

Overview:
- Inverse of the 32->24 AXIS byte-strip block: widens a 24-bit AXI4-Stream (RGB pixel) to 32 bits by inserting a pad byte in [31:24].
- Registered with a 2-entry skid buffer so both tready and tdata/tvalid are timing-clean at full throughput.
- Sits between 24-bit video/accel outputs and 32-bit DMA (MM2S/S2MM) ports in the DFX slot.
- Also provides per-packet beat and packet counters for debug.

Parameters:
- PAD_VALUE, 8'h00: constant byte driven on out_AXIS_tdata[31:24].
- CNT_W, 16: width of beat_count and pkt_count.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- in_AXIS_tdata  in  24  input pixel data.
- in_AXIS_tvalid  in  1  input valid.
- in_AXIS_tlast  in  1  input end of packet.
- in_AXIS_tready  out  1  input ready; registered.
- out_AXIS_tdata  out  32  {pad, in data}.
- out_AXIS_tvalid  out  1  output valid; registered.
- out_AXIS_tlast  out  1  output end of packet.
- out_AXIS_tready  in  1  downstream ready.
- beat_count  out  CNT_W  beats accepted in the current packet so far.
- pkt_count  out  CNT_W  completed packets (tlast beats emitted).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_AXIS_tvalid=0, out_AXIS_tdata=0, out_AXIS_tlast=0, in_AXIS_tready=0 during reset and 1 on the first cycle after, beat_count=0, pkt_count=0, skid register empty.
- Data mapping: out_AXIS_tdata = {PAD_VALUE, in_AXIS_tdata}; tlast passes through unmodified with its beat.
- Storage: main output register M and skid register S, each holding {data[23:0], last, valid}.
- Input accept: in_fire = in_AXIS_tvalid & in_AXIS_tready. Output fire: out_fire = out_AXIS_tvalid & out_AXIS_tready.
- in_AXIS_tready is registered: next value = ~S.valid_next. It is 1 whenever S is empty.
- State is encoded by (M.valid, S.valid):
  - EMPTY (0,0): in_fire loads M -> ONE.
  - ONE (1,0):
    - in_fire & out_fire: reload M, stay in ONE.
    - in_fire & ~out_fire: load S -> FULL, and tready drops next cycle.
    - ~in_fire & out_fire: -> EMPTY.
  - FULL (1,1): tready=0. out_fire moves S->M -> ONE. No input is accepted in FULL.
- Latency: 1 cycle from in_fire to out_AXIS_tvalid. Throughput is 1 beat/cycle with out_AXIS_tready held high.
- AXIS rules:
  - out_AXIS_tdata/tlast are stable while tvalid=1 and tready=0.
  - out_AXIS_tvalid never depends combinationally on out_AXIS_tready.
  - Beat order is preserved and no beat is dropped or duplicated.
- beat_count:
  - Increments on in_fire.
  - On in_fire with in_AXIS_tlast=1, resets to 0 on the same edge instead of incrementing.
  - Wraps modulo 2^CNT_W.
- pkt_count: increments on out_fire with out_AXIS_tlast=1; wraps modulo 2^CNT_W.
- Reset mid-packet: all buffered beats are discarded and counters are cleared; no partial output follows reset.
- A single-beat packet (tlast on the first beat) is legal and counts as one packet.

Optional Feature:
- Macro: AXIS_PAD_SOF_EN.
- Defined:
  - Adds output out_AXIS_tuser (1 bit), asserted on the first beat of each packet (first beat after reset or after a tlast beat).
  - The flag is computed on the input side, stored per entry in M/S, and held stable under backpressure.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Package axis_pad_pkg:
  - Constants IN_W=24, OUT_W=32, PAD_W=8.
  - Typedef beat_t = struct {data[23:0], last, sof}.
  - Default PAD_VALUE.
- One sub-module, axis_skid_buf: generic 2-entry skid buffer parameterised on payload width.
- axis_pad instantiates axis_skid_buf and adds the pad insertion and counters.

Test Plan:
- Streaming: 8-beat packet, data 24'h000001..24'h000008, tlast on beat 8, out_tready=1 constant, PAD_VALUE=8'hFF -> out 32'hFF000001..32'hFF000008 on consecutive cycles, 1-cycle latency, tlast on the 8th beat, pkt_count=1, beat_count=0 afterwards.
- Backpressure: out_tready low for 3 cycles mid-stream -> in_tready falls 1 cycle after S fills, output held stable, no loss or duplication; check with a 100-beat random-ready scoreboard.
- Single-beat packets: 5 consecutive single-beat packets (tlast=1 on each beat) -> pkt_count=5 and beat_count stays 0; with AXIS_PAD_SOF_EN, tuser=1 on all 5 beats.
- Reset with FULL buffer: reset asserted while the buffer is FULL -> next cycle out_tvalid=0, counters 0; the first post-reset beat appears with tuser=1 (if enabled).
- Counter wrap: CNT_W=4, 17 packets -> pkt_count=1; a 20-beat packet without tlast -> beat_count=4.
- Ready toggling: out_tready toggled every cycle with in_tvalid held high -> net throughput 1 beat per 2 cycles, order preserved.
